// File: rtl/fir_transposed_param.sv
// Transposed-form FIR with TAPS signed taps, a run-time writable coefficient bank and valid strobes.
// Define FIR_SAT_EN to saturate the accumulator into y; otherwise y is the two's-complement wrap of acc.
module fir_transposed_param #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int TAPS   = 3,
   parameter int OUT_W  = 16,
   parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     coef_we,
   input  logic [$clog2(TAPS)-1:0]  coef_addr,
   input  logic [COEF_W-1:0]        coef_wdata,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        x,
   output logic                     out_valid,
   output logic [OUT_W-1:0]         y
);

   localparam int AW = $clog2(TAPS);

   // Strobe semantics: there is no ready. A sample is taken on every posedge with
   // in_valid=1 (unless rst/clr), and y is valid for exactly the one cycle out_valid=1.

   logic signed [COEF_W-1:0] coef_q [TAPS];
   logic signed [COEF_W-1:0] coef_d [TAPS];
   logic signed [ACC_W-1:0]  d_q [TAPS-1];
   logic signed [ACC_W-1:0]  d_d [TAPS-1];
   logic signed [ACC_W-1:0]  x_ext;
   logic signed [ACC_W-1:0]  c_ext [TAPS];
   logic signed [ACC_W-1:0]  prod [TAPS];
   logic [OUT_W-1:0]         y_q, y_d, y_red;
   logic                     out_valid_q, out_valid_d;

   always_comb begin
      x_ext = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
      for (int k = 0; k < TAPS; k++) begin
         c_ext[k] = {{(ACC_W-COEF_W){coef_q[k][COEF_W-1]}}, coef_q[k]};
         prod[k]  = x_ext * c_ext[k];
      end
   end

`ifdef FIR_SAT_EN
   logic signed [ACC_W-1:0] acc;

   // acc fits in OUT_W exactly when all bits from the OUT_W sign position upward agree.
   always_comb begin
      acc = prod[0] + d_q[0];
      if ((&acc[ACC_W-1:OUT_W-1]) || (~|acc[ACC_W-1:OUT_W-1])) begin
         y_red = acc[OUT_W-1:0];
      end else if (acc[ACC_W-1]) begin
         y_red = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         y_red = {1'b0, {(OUT_W-1){1'b1}}};
      end
   end
`else
   always_comb begin
      y_red = OUT_W'(prod[0] + d_q[0]);
   end
`endif

   always_comb begin
      coef_d      = coef_q;
      d_d         = d_q;
      y_d         = y_q;
      out_valid_d = 1'b0;
      // Products above use coef_q, so a write only affects samples from the next cycle on.
      for (int k = 0; k < TAPS; k++) begin
         if (coef_we && (coef_addr == AW'(k))) begin
            coef_d[k] = coef_wdata;
         end
      end
      if (clr) begin
         for (int k = 0; k < TAPS-1; k++) begin
            d_d[k] = '0;
         end
      end else if (in_valid) begin
         for (int k = 0; k < TAPS-2; k++) begin
            d_d[k] = d_q[k+1] + prod[k+1];
         end
         d_d[TAPS-2] = prod[TAPS-1];
         y_d         = y_red;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) begin
            coef_q[k] <= '0;
         end
         for (int k = 0; k < TAPS-1; k++) begin
            d_q[k] <= '0;
         end
         y_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         coef_q      <= coef_d;
         d_q         <= d_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign y         = y_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_transposed_param.sv
// Directed bench for fir_transposed_param: default 3-tap instance plus 12-bit instances
// with TAPS = 2, 8, 64 checked against a direct convolution model.
module tb_fir_transposed_param;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        coef_we = 1'b0;
   logic [1:0]  coef_addr = '0;
   logic [7:0]  coef_wdata = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  x = '0;
   logic        out_valid;
   logic [15:0] y;

   // Sweep instances share x / in_valid / clr; each has its own coefficient port.
   logic        s_clr = 1'b0;
   logic        s_in_valid = 1'b0;
   logic [11:0] s_x = '0;
   logic        we2 = 1'b0, we8 = 1'b0, we64 = 1'b0;
   logic [0:0]  addr2 = '0;
   logic [2:0]  addr8 = '0;
   logic [5:0]  addr64 = '0;
   logic [11:0] wd2 = '0, wd8 = '0, wd64 = '0;
   logic        ov2, ov8, ov64;
   logic [24:0] y2;
   logic [26:0] y8;
   logic [29:0] y64;

   int tests_run = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fir_transposed_param dut (
      .clk(clk), .rst(rst), .clr(clr), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_wdata(coef_wdata), .in_valid(in_valid), .x(x), .out_valid(out_valid), .y(y)
   );

   fir_transposed_param #(.DATA_W(12), .COEF_W(12), .TAPS(2), .OUT_W(25)) dut_s2 (
      .clk(clk), .rst(rst), .clr(s_clr), .coef_we(we2), .coef_addr(addr2),
      .coef_wdata(wd2), .in_valid(s_in_valid), .x(s_x), .out_valid(ov2), .y(y2)
   );

   fir_transposed_param #(.DATA_W(12), .COEF_W(12), .TAPS(8), .OUT_W(27)) dut_s8 (
      .clk(clk), .rst(rst), .clr(s_clr), .coef_we(we8), .coef_addr(addr8),
      .coef_wdata(wd8), .in_valid(s_in_valid), .x(s_x), .out_valid(ov8), .y(y8)
   );

   fir_transposed_param #(.DATA_W(12), .COEF_W(12), .TAPS(64), .OUT_W(30)) dut_s64 (
      .clk(clk), .rst(rst), .clr(s_clr), .coef_we(we64), .coef_addr(addr64),
      .coef_wdata(wd64), .in_valid(s_in_valid), .x(s_x), .out_valid(ov64), .y(y64)
   );

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input int addr, input int val);
      coef_we    = 1'b1;
      coef_addr  = 2'(addr);
      coef_wdata = 8'(val);
      step();
      coef_we    = 1'b0;
   endtask

   task automatic clear_line();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || y !== 16'd0) begin
         fails++;
         $display("FAIL reset: out_valid=%b y=%0d, want 0 0", out_valid, $signed(y));
      end
      step();
      tests_run++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: out_valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_impulse();
      logic signed [15:0] e [5] = '{16'sd3, -16'sd2, 16'sd5, 16'sd0, 16'sd0};
      write_coef(0, 3);
      write_coef(1, -2);
      write_coef(2, 5);
      clear_line();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         x = (i == 0) ? 8'd1 : 8'd0;
         step();
         tests_run++;
         if (out_valid !== 1'b1 || y !== e[i]) begin
            fails++;
            $display("FAIL impulse[%0d]: out_valid=%b y=%0d, want 1 %0d", i, out_valid, $signed(y), e[i]);
         end
      end
      in_valid = 1'b0;
      step();
      tests_run++;
      if (out_valid !== 1'b0 || y !== 16'd0) begin
         fails++;
         $display("FAIL impulse_end: out_valid=%b y=%0d, want 0 0", out_valid, $signed(y));
      end
   endtask

   task automatic test_gaps();
      logic signed [15:0] e [4] = '{16'sd3, 16'sd1, 16'sd6, 16'sd6};
      clear_line();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         x = 8'd1;
         step();
         tests_run++;
         if (out_valid !== 1'b1 || y !== e[i]) begin
            fails++;
            $display("FAIL gaps[%0d]: out_valid=%b y=%0d, want 1 %0d", i, out_valid, $signed(y), e[i]);
         end
         in_valid = 1'b0;
         x = 8'd99;
         step();
         tests_run++;
         if (out_valid !== 1'b0 || y !== e[i]) begin
            fails++;
            $display("FAIL gaps_hold[%0d]: out_valid=%b y=%0d, want 0 %0d", i, out_valid, $signed(y), e[i]);
         end
      end
   endtask

   task automatic test_coef_write();
      logic signed [15:0] e [8] = '{16'sd2, 16'sd4, 16'sd6, 16'sd6, 16'sd6, 16'sd6, 16'sd12, 16'sd12};
      logic signed [15:0] e2 [4] = '{16'sd2, 16'sd1, 16'sd4, 16'sd0};
      write_coef(0, 1);
      write_coef(1, 1);
      write_coef(2, 1);
      clear_line();
      for (int i = 0; i < 8; i++) begin
         in_valid   = 1'b1;
         x          = 8'd2;
         coef_we    = (i == 3);
         coef_addr  = 2'd2;
         coef_wdata = 8'd4;
         step();
         coef_we = 1'b0;
         tests_run++;
         if (out_valid !== 1'b1 || y !== e[i]) begin
            fails++;
            $display("FAIL coef_mid[%0d]: out_valid=%b y=%0d, want 1 %0d", i, out_valid, $signed(y), e[i]);
         end
      end
      // Write c[0] during clr, then an out-of-range address that must be ignored.
      in_valid   = 1'b0;
      clr        = 1'b1;
      coef_we    = 1'b1;
      coef_addr  = 2'd0;
      coef_wdata = 8'd2;
      step();
      clr = 1'b0;
      write_coef(3, 7);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         x = (i == 0) ? 8'd1 : 8'd0;
         step();
         tests_run++;
         if (out_valid !== 1'b1 || y !== e2[i]) begin
            fails++;
            $display("FAIL coef_clr_oor[%0d]: out_valid=%b y=%0d, want 1 %0d", i, out_valid, $signed(y), e2[i]);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_clr();
      logic signed [15:0] e1 [3] = '{16'sd1, 16'sd2, 16'sd3};
      logic signed [15:0] e2 [4] = '{16'sd2, 16'sd5, 16'sd9, 16'sd9};
      write_coef(0, 1);
      write_coef(1, 1);
      write_coef(2, 1);
      clear_line();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         x = 8'd1;
         step();
         tests_run++;
         if (y !== e1[i]) begin
            fails++;
            $display("FAIL rc_pre[%0d]: y=%0d, want %0d", i, $signed(y), e1[i]);
         end
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || y !== 16'd0) begin
         fails++;
         $display("FAIL rc_rst: out_valid=%b y=%0d, want 0 0", out_valid, $signed(y));
      end
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (out_valid !== 1'b1 || y !== 16'd0) begin
            fails++;
            $display("FAIL rc_zero_coef[%0d]: out_valid=%b y=%0d, want 1 0", i, out_valid, $signed(y));
         end
      end
      in_valid = 1'b0;
      write_coef(0, 2);
      write_coef(1, 3);
      write_coef(2, 4);
      clear_line();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         step();
         tests_run++;
         if (y !== e2[i]) begin
            fails++;
            $display("FAIL rc_reprog[%0d]: y=%0d, want %0d", i, $signed(y), e2[i]);
         end
      end
      clr = 1'b1;
      step();
      clr = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || y !== 16'sd9) begin
         fails++;
         $display("FAIL rc_clr: out_valid=%b y=%0d, want 0 9", out_valid, $signed(y));
      end
      step();
      tests_run++;
      if (out_valid !== 1'b1 || y !== 16'sd2) begin
         fails++;
         $display("FAIL rc_after_clr0: out_valid=%b y=%0d, want 1 2", out_valid, $signed(y));
      end
      step();
      tests_run++;
      if (y !== 16'sd5) begin
         fails++;
         $display("FAIL rc_after_clr1: y=%0d, want 5", $signed(y));
      end
      in_valid = 1'b0;
   endtask

   task automatic test_overflow();
`ifdef FIR_SAT_EN
      logic signed [15:0] e [4] = '{-16'sd16256, -16'sd32512, -16'sd32768, -16'sd32768};
`else
      logic signed [15:0] e [4] = '{-16'sd16256, -16'sd32512, 16'sd16768, 16'sd16768};
`endif
      write_coef(0, 127);
      write_coef(1, 127);
      write_coef(2, 127);
      clear_line();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         x = 8'h80;
         step();
         tests_run++;
         if (out_valid !== 1'b1 || y !== e[i]) begin
            fails++;
            $display("FAIL overflow[%0d]: out_valid=%b y=%0d, want 1 %0d", i, out_valid, $signed(y), e[i]);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_sweep();
      longint c2 [2];
      longint c8 [8];
      longint c64 [64];
      longint hist [64];
      longint e2, e8, e64;
      logic signed [11:0] v;
      logic acc_now, clr_now;
      for (int i = 0; i < 64; i++) begin
         v = 12'($urandom_range(0, 4095));
         c64[i] = v;
         we64 = 1'b1; addr64 = 6'(i); wd64 = v;
         v = 12'($urandom_range(0, 4095));
         if (i < 8) c8[i] = v;
         we8 = (i < 8); addr8 = 3'(i % 8); wd8 = v;
         v = 12'($urandom_range(0, 4095));
         if (i < 2) c2[i] = v;
         we2 = (i < 2); addr2 = 1'(i % 2); wd2 = v;
         step();
      end
      we2 = 1'b0; we8 = 1'b0; we64 = 1'b0;
      s_clr = 1'b1;
      step();
      s_clr = 1'b0;
      for (int k = 0; k < 64; k++) hist[k] = 0;
      e2 = 0; e8 = 0; e64 = 0;
      for (int i = 0; i < 300; i++) begin
         clr_now    = (i == 150);
         acc_now    = ($urandom_range(0, 3) != 0) && !clr_now;
         v          = 12'($urandom_range(0, 4095));
         s_clr      = clr_now;
         s_in_valid = acc_now || clr_now;
         s_x        = v;
         if (clr_now) begin
            for (int k = 0; k < 64; k++) hist[k] = 0;
         end else if (acc_now) begin
            for (int k = 63; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = v;
            e2 = 0; e8 = 0; e64 = 0;
            for (int k = 0; k < 64; k++) begin
               e64 += c64[k] * hist[k];
               if (k < 8) e8 += c8[k] * hist[k];
               if (k < 2) e2 += c2[k] * hist[k];
            end
         end
         step();
         tests_run++;
         if (acc_now) begin
            if (ov2 !== 1'b1 || y2 !== 25'(e2) || ov8 !== 1'b1 || y8 !== 27'(e8) ||
                ov64 !== 1'b1 || y64 !== 30'(e64)) begin
               fails++;
               $display("FAIL sweep[%0d]: got %b/%0d %b/%0d %b/%0d, want 1/%0d 1/%0d 1/%0d", i,
                        ov2, $signed(y2), ov8, $signed(y8), ov64, $signed(y64), e2, e8, e64);
            end
         end else begin
            if (ov2 !== 1'b0 || ov8 !== 1'b0 || ov64 !== 1'b0) begin
               fails++;
               $display("FAIL sweep_gap[%0d]: out_valid %b %b %b, want 0 0 0", i, ov2, ov8, ov64);
            end
         end
      end
      s_in_valid = 1'b0;
      s_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_impulse();
      test_gaps();
      test_coef_write();
      test_reset_clr();
      test_overflow();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
